pc_fetch_unit: RTL and testbench

//  Instruction-fetch stage directly upstream of the decoder/control unit. Holds the PC, fetches
//  one 32-bit word per instruction over a busywait instruction-memory handshake, and presents it
//  to the decoder with a one-cycle-per-instruction valid window.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/pc_next_calc.sv | 21 ++
 rtl/pc_fetch_unit.sv | 103 ++++++++++
 tb/tb_pc_fetch_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_e;

  localparam int INSTR_W  = 32;
  localparam int PC_STEP  = 4;
  localparam int OFFSET_W = 8;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential PC+4 or PC+4 plus a signed word offset.
module pc_next_calc
  import fetch_pkg::*;
(
  input  logic [INSTR_W-1:0]  pc,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                flowselect,
  output logic [INSTR_W-1:0]  next_pc
);

  logic [INSTR_W-1:0] seq_pc;
  logic [INSTR_W-1:0] rel_bytes;

  assign seq_pc = pc + INSTR_W'(PC_STEP);

  // Word offset to byte offset: sign-extend, then scale by 4. Wrap-around is intended.
  assign rel_bytes = {{(INSTR_W - OFFSET_W - 2){offset[OFFSET_W-1]}}, offset, 2'b00};

  assign next_pc = flowselect ? (seq_pc + rel_bytes) : seq_pc;

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, busywait IMEM handshake, one-cycle decode window.
// Optional busywait timeout flag is built when FETCH_TIMEOUT_EN is defined.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC       = 32'h0000_0000,
  parameter int                 TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flowselect,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                stall,
  input  logic [INSTR_W-1:0]  imem_readdata,
  input  logic                imem_busywait,
  output logic [INSTR_W-1:0]  pc,
  output logic [INSTR_W-1:0]  imem_address,
  output logic                imem_read,
  output logic [INSTR_W-1:0]  instruction,
  output logic                instr_valid,
  output logic                fetch_timeout
);

  fetch_state_e       state, next_state;
  logic               load_instr;
  logic               load_pc;
  logic [INSTR_W-1:0] next_pc;

  pc_next_calc u_pc_next_calc (
    .pc         (pc),
    .offset     (offset),
    .flowselect (flowselect),
    .next_pc    (next_pc)
  );

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    next_state = state;
    load_instr = 1'b0;
    load_pc    = 1'b0;
    unique case (state)
      S_FETCH, S_WAIT: begin
        if (!imem_busywait) begin
          load_instr = 1'b1;
          next_state = S_EXEC;
        end else begin
          next_state = S_WAIT;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          load_pc    = 1'b1;
          next_state = S_FETCH;
        end
      end
      default: next_state = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      instruction <= '0;
    end else begin
      state <= next_state;
      if (load_pc)    pc          <= next_pc;
      if (load_instr) instruction <= imem_readdata;
    end
  end

  assign imem_address = pc;
  assign instr_valid  = (state == S_EXEC);
  // Read request follows the registered state but is forced low while reset is asserted.
  assign imem_read    = rst_n && (state != S_EXEC);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_inc;
  logic             timeout_q;

  assign wait_cnt_inc = (&wait_cnt) ? wait_cnt : wait_cnt + CNT_W'(1);

  // The flag only reports; the fetch keeps waiting for the memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (state == S_WAIT) begin
      wait_cnt <= (next_state == S_WAIT) ? wait_cnt_inc : '0;
      if (wait_cnt_inc == CNT_W'(TIMEOUT_CYCLES)) timeout_q <= 1'b1;
    end
  end

  assign fetch_timeout = timeout_q;
`else
  assign fetch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table plus reset and timeout sequences.
module tb_pc_fetch_unit;

  localparam logic [31:0] SALT  = 32'hC0DE_5A00;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;
  localparam logic [31:0] JUNK2 = 32'hBAD0_0BAD;
`ifdef FETCH_TIMEOUT_EN
  localparam logic EXP_TIMEOUT = 1'b1;
`else
  localparam logic EXP_TIMEOUT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flowselect;
  logic [7:0]  offset;
  logic        stall;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic [31:0] pc;
  logic [31:0] imem_address;
  logic        imem_read;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        fetch_timeout;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        fs;
    logic [7:0]  off;
    int          nbusy;
    int          nstall;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[13];

  pc_fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flowselect    (flowselect),
    .offset        (offset),
    .stall         (stall),
    .imem_readdata (imem_readdata),
    .imem_busywait (imem_busywait),
    .pc            (pc),
    .imem_address  (imem_address),
    .imem_read     (imem_read),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .fetch_timeout (fetch_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One instruction: fetch with nbusy busywait cycles, then nstall stalled exec cycles.
  // Called and returns at a negedge where the DUT should be in S_FETCH.
  task automatic run_instr(input logic fs, input logic [7:0] off, input int nbusy,
                           input int nstall, input logic [31:0] exp_pc);
    logic [31:0] word;
    logic [31:0] want;
    word = exp_pc ^ SALT;
    check("fetch_pc", pc, exp_pc);
    check("fetch_addr", imem_address, exp_pc);
    check("fetch_read", {31'd0, imem_read}, 32'd1);
    exp_q.push_back(word);
    imem_busywait = (nbusy > 0);
    imem_readdata = (nbusy > 0) ? JUNK : word;
    stall      = 1'b1;
    flowselect = 1'b1;
    offset     = 8'hAA;
    for (int i = 0; i < nbusy; i++) begin
      @(negedge clk);
      check("wait_read", {31'd0, imem_read}, 32'd1);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
      check("wait_pc", pc, exp_pc);
      if (i == nbusy - 1) begin
        imem_busywait = 1'b0;
        imem_readdata = word;
      end
    end
    if (nstall == 0) begin
      stall      = 1'b0;
      flowselect = fs;
      offset     = off;
    end else begin
      stall      = 1'b1;
      flowselect = 1'b1;
      offset     = 8'h81;
    end
    @(negedge clk);
    imem_readdata = JUNK2;
    check("exec_valid", {31'd0, instr_valid}, 32'd1);
    check("exec_read", {31'd0, imem_read}, 32'd0);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=none required=%h", word);
    end else begin
      want = exp_q.pop_front();
      check("instruction", instruction, want);
    end
    for (int i = 0; i < nstall; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_pc", pc, exp_pc);
      check("stall_instr", instruction, word);
      if (i == nstall - 1) begin
        stall      = 1'b0;
        flowselect = fs;
        offset     = off;
      end
    end
    @(negedge clk);
    stall      = 1'b1;
    flowselect = 1'b1;
    offset     = 8'h7E;
    check("next_valid", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs = '{
      '{1'b0, 8'h00, 0, 0, 32'h0000_0000},
      '{1'b0, 8'h00, 0, 0, 32'h0000_0004},
      '{1'b0, 8'h00, 0, 0, 32'h0000_0008},
      '{1'b0, 8'h00, 0, 0, 32'h0000_000C},
      '{1'b1, 8'hFE, 0, 0, 32'h0000_0010},
      '{1'b0, 8'h00, 3, 0, 32'h0000_000C},
      '{1'b1, 8'h03, 0, 4, 32'h0000_0010},
      '{1'b1, 8'h80, 1, 2, 32'h0000_0020},
      '{1'b1, 8'h7F, 0, 0, 32'hFFFF_FE24},
      '{1'b0, 8'h00, 2, 1, 32'h0000_0024},
      '{1'b1, 8'hF4, 0, 0, 32'h0000_0028},
      '{1'b0, 8'h00, 0, 0, 32'hFFFF_FFFC},
      '{1'b0, 8'h00, 0, 0, 32'h0000_0000}
    };

    rst_n         = 1'b0;
    flowselect    = 1'b0;
    offset        = 8'h00;
    stall         = 1'b0;
    imem_readdata = 32'h0;
    imem_busywait = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_read", {31'd0, imem_read}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_timeout", {31'd0, fetch_timeout}, 32'd0);
    rst_n = 1'b1;
    #1;

    for (int v = 0; v < 13; v++)
      run_instr(vecs[v].fs, vecs[v].off, vecs[v].nbusy, vecs[v].nstall, vecs[v].pc);

    // Long busywait: timeout flag sets (when built in) and stays set.
    run_instr(1'b0, 8'h00, 6, 0, 32'h0000_0004);
    check("timeout_set", {31'd0, fetch_timeout}, {31'd0, EXP_TIMEOUT});
    run_instr(1'b0, 8'h00, 0, 0, 32'h0000_0008);
    check("timeout_sticky", {31'd0, fetch_timeout}, {31'd0, EXP_TIMEOUT});

    // Reset for 3 cycles in the middle of S_WAIT; the in-flight word is dropped.
    imem_busywait = 1'b1;
    imem_readdata = JUNK;
    repeat (2) @(negedge clk);
    check("midwait_pc", pc, 32'h0000_000C);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_read", {31'd0, imem_read}, 32'd0);
      check("reset_pc", pc, 32'h0);
      check("reset_timeout", {31'd0, fetch_timeout}, 32'd0);
      @(negedge clk);
    end
    rst_n         = 1'b1;
    imem_busywait = 1'b0;
    #1;
    check("first_read", {31'd0, imem_read}, 32'd1);
    check("first_addr", imem_address, 32'h0);
    run_instr(1'b0, 8'h00, 0, 0, 32'h0000_0000);
    run_instr(1'b1, 8'h00, 0, 0, 32'h0000_0004);
    check("final_pc", pc, 32'h0000_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
